// File: rtl/dfs_pkg.sv
// Shared DFS definitions: level encodings, clock-gen FSM states and the
// level-to-divide-ratio mapping. The DFS controller reuses the encodings.
package dfs_pkg;

    localparam logic [1:0] SEL_LOW     = 2'b00;
    localparam logic [1:0] SEL_MED     = 2'b01;
    localparam logic [1:0] SEL_HIGH    = 2'b10;
    localparam logic [1:0] SEL_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        WAIT_BOUNDARY = 2'd1,
        SETTLE        = 2'd2
    } dfs_state_e;

    // Divide ratio for a level; the illegal code falls back to LOW.
    function automatic int unsigned sel_to_div(input logic [1:0] sel,
                                               input int unsigned div_low,
                                               input int unsigned div_med,
                                               input int unsigned div_high);
        case (sel)
            SEL_MED:  return div_med;
            SEL_HIGH: return div_high;
            default:  return div_low;
        endcase
    endfunction

endpackage

// File: rtl/dfs_clk_gen_if.sv
// DFS select / clock-enable bundle between the DFS controller (master) and
// the clock-enable generator (slave). With DFS_STATS_EN defined the bundle
// also carries the 16-bit applied-switch counter.
interface dfs_clk_gen_if;
    logic [1:0]  dfs_sel;
    logic        clk_en;
    logic [1:0]  cur_sel;
    logic        switching;
    logic        switch_done;
    logic        err_sel;
`ifdef DFS_STATS_EN
    logic [15:0] switch_count;
`endif

`ifdef DFS_STATS_EN
    modport master (output dfs_sel,
                    input  clk_en, cur_sel, switching, switch_done, err_sel, switch_count);
    modport slave  (input  dfs_sel,
                    output clk_en, cur_sel, switching, switch_done, err_sel, switch_count);
`else
    modport master (output dfs_sel,
                    input  clk_en, cur_sel, switching, switch_done, err_sel);
    modport slave  (input  dfs_sel,
                    output clk_en, cur_sel, switching, switch_done, err_sel);
`endif
endinterface

// File: rtl/dfs_div_counter.sv
// Divide counter: free-running cnt wrapping at div-1, clk_en decoded from
// registers, synchronous load of a new ratio that also restarts the period.
module dfs_div_counter #(
    parameter int CNT_W   = 8,
    parameter int DIV_RST = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_load,
    input  logic [CNT_W:0] i_div,
    output logic           o_clk_en
);
    localparam int DW = CNT_W + 1;

    logic [DW-1:0]    r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    // Ratio may be 2^CNT_W, so the ratio register is one bit wider than cnt.
    assign w_wrap   = ({1'b0, r_cnt} == (r_div - DW'(1)));
    assign o_clk_en = w_wrap & ~rst;

    // Count within the period; a load restarts at cnt=0 with the new ratio.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= DW'(DIV_RST);
            r_cnt <= '0;
        end else if (i_load) begin
            r_div <= i_div;
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dfs_clk_gen.sv
// DFS clock-enable generator: applies a requested level only at a divide
// period boundary, then holds a settle window before accepting another.
// Optional macro DFS_STATS_EN adds a saturating applied-switch counter.
module dfs_clk_gen #(
    parameter int DIV_LOW    = 4,
    parameter int DIV_MED    = 2,
    parameter int DIV_HIGH   = 1,
    parameter int CNT_W      = 8,
    parameter int SETTLE_CYC = 16
) (
    input  logic         clk,
    input  logic         rst,
    dfs_clk_gen_if.slave bus
);
    import dfs_pkg::*;

    localparam int DW = CNT_W + 1;
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    dfs_state_e  r_state, w_state_nxt;
    logic [1:0]  r_target, w_target_nxt;
    logic [1:0]  r_cur_sel;
    logic [SW-1:0] r_settle;
    logic        r_switch_done;
    logic        r_err_sel;
    logic        w_do_switch;
    logic        w_clk_en;
    logic        w_sel_legal;
    logic [DW-1:0] w_div_tgt;

    assign w_sel_legal = (bus.dfs_sel != SEL_ILLEGAL);
    assign w_div_tgt   = DW'(sel_to_div(r_target, DIV_LOW, DIV_MED, DIV_HIGH));

    dfs_div_counter #(
        .CNT_W   (CNT_W),
        .DIV_RST (DIV_LOW)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_do_switch),
        .i_div    (w_div_tgt),
        .o_clk_en (w_clk_en)
    );

    // Next state / target: a boundary in WAIT_BOUNDARY switches to the
    // already-registered target, taking priority over any same-cycle request.
    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_do_switch  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sel_legal && (bus.dfs_sel != r_cur_sel)) begin
                    w_target_nxt = bus.dfs_sel;
                    w_state_nxt  = WAIT_BOUNDARY;
                end
            end
            WAIT_BOUNDARY: begin
                if (w_clk_en) begin
                    w_do_switch = 1'b1;
                    w_state_nxt = SETTLE;
                end else if (w_sel_legal) begin
                    if (bus.dfs_sel == r_cur_sel) w_state_nxt  = IDLE;
                    else                          w_target_nxt = bus.dfs_sel;
                end
            end
            SETTLE: begin
                if (r_settle == SW'(SETTLE_CYC - 1)) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state and pending target registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_target <= SEL_LOW;
        end else begin
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
        end
    end

    // Applied level, settle timer, switch pulse and illegal-select flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_sel     <= SEL_LOW;
            r_settle      <= '0;
            r_switch_done <= 1'b0;
            r_err_sel     <= 1'b0;
        end else begin
            r_switch_done <= w_do_switch;
            r_err_sel     <= (bus.dfs_sel == SEL_ILLEGAL);
            if (w_do_switch) begin
                r_cur_sel <= r_target;
                r_settle  <= '0;
            end else if (r_state == SETTLE) begin
                r_settle  <= r_settle + SW'(1);
            end
        end
    end

`ifdef DFS_STATS_EN
    logic [15:0] r_switch_count;

    // Count applied switches, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     r_switch_count <= '0;
        else if (w_do_switch && (r_switch_count != 16'hFFFF)) r_switch_count <= r_switch_count + 16'd1;
    end

    assign bus.switch_count = r_switch_count;
`endif

    assign bus.clk_en      = w_clk_en;
    assign bus.cur_sel     = r_cur_sel;
    assign bus.switching   = (r_state == WAIT_BOUNDARY) || (r_state == SETTLE);
    assign bus.switch_done = r_switch_done;
    assign bus.err_sel     = r_err_sel;

endmodule

// File: tb/tb_dfs_clk_gen.sv
// Bench for dfs_clk_gen: directed scenarios with hand-derived expectations
// plus a randomized run against a cycle-level behavioural model.
module tb_dfs_clk_gen;

    localparam int SETTLE = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dfs_clk_gen_if bus();

    dfs_clk_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: applied level, position inside the current period,
    // a pending flag + target, and cycles of settle window still to run.
    int m_lvl, m_pos, m_tgt, m_settle_left, m_cnt;
    bit m_pend, m_done, m_err;

    function automatic int div_of(input int l);
        if (l == 1) return 2;
        if (l == 2) return 1;
        return 4;
    endfunction

    task automatic model_reset();
        m_lvl = 0; m_pos = 0; m_tgt = 0; m_settle_left = 0; m_cnt = 0;
        m_pend = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_step(input logic [1:0] sel);
        bit bnd;
        bit sw;
        bnd = (m_pos == div_of(m_lvl) - 1);
        sw  = 0;
        m_err = (sel == 2'b11);
        if (m_settle_left > 0) begin
            m_settle_left--;
        end else if (m_pend) begin
            if (bnd) begin
                m_lvl = m_tgt; m_pend = 0; m_settle_left = SETTLE; sw = 1;
            end else if (sel != 2'b11) begin
                if (int'(sel) == m_lvl) m_pend = 0;
                else                    m_tgt  = int'(sel);
            end
        end else if (sel != 2'b11 && int'(sel) != m_lvl) begin
            m_pend = 1; m_tgt = int'(sel);
        end
        m_done = sw;
        if (sw && m_cnt < 65535) m_cnt++;
        m_pos = (sw || bnd) ? 0 : m_pos + 1;
    endtask

    function automatic logic [5:0] model_out();
        logic en, swi;
        en  = (m_pos == div_of(m_lvl) - 1);
        swi = m_pend || (m_settle_left > 0);
        return {en, 2'(m_lvl), swi, m_done, m_err};
    endfunction

    function automatic logic [5:0] dut_out();
        return {bus.clk_en, bus.cur_sel, bus.switching, bus.switch_done, bus.err_sel};
    endfunction

    // Drive the select for the current cycle and advance one clock.
    task automatic tick(input logic [1:0] sel);
        bus.dfs_sel = sel;
        model_step(sel);
        @(posedge clk);
        #1;
    endtask

    // Reset then release just after an edge; the caller is then in cycle 1.
    task automatic release_rst();
        rst = 1'b1;
        bus.dfs_sel = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        logic [5:0] got;
        rst = 1'b1;
        bus.dfs_sel = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        got = dut_out();
        total++;
        if (got !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=%b", got, 6'b0);
        end
`ifdef DFS_STATS_EN
        total++;
        if (bus.switch_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_count got=%0d exp=0", bus.switch_count);
        end
`endif
    endtask

    task automatic test_low_cadence();
        logic [5:0] got, exp;
        release_rst();
        for (int c = 1; c <= 20; c++) begin
            got = dut_out();
            exp = {(c % 4 == 0), 2'b00, 1'b0, 1'b0, 1'b0};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL low_cadence cyc=%0d got=%b exp=%b", c, got, exp);
            end
            tick(2'b00);
        end
    endtask

    task automatic test_switch_high_med();
        logic [5:0] got, exp;
        logic en, swi, done;
        logic [1:0] cur, sel;
        release_rst();
        for (int c = 1; c <= 32; c++) begin
            en   = (c <= 8) ? (c % 4 == 0) : (c <= 26) ? 1'b1 : (c % 2 == 0);
            cur  = (c <= 8) ? 2'b00 : (c <= 26) ? 2'b10 : 2'b01;
            swi  = (c >= 6 && c <= 24) || (c >= 26);
            done = (c == 9) || (c == 27);
            exp  = {en, cur, swi, done, 1'b0};
            got  = dut_out();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL switch_high_med cyc=%0d got=%b exp=%b", c, got, exp);
            end
            sel = (c < 5) ? 2'b00 : (c < 12) ? 2'b10 : 2'b01;
            tick(sel);
        end
    endtask

    task automatic test_cancel();
        logic [5:0] got, exp;
        release_rst();
        for (int c = 1; c <= 16; c++) begin
            exp = {(c % 4 == 0), 2'b00, (c == 6), 1'b0, 1'b0};
            got = dut_out();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL cancel cyc=%0d got=%b exp=%b", c, got, exp);
            end
            tick((c == 5) ? 2'b01 : 2'b00);
        end
    endtask

    task automatic test_illegal();
        logic [5:0] got, exp;
        release_rst();
        for (int c = 1; c <= 12; c++) begin
            exp = {(c % 4 == 0), 2'b00, 1'b0, 1'b0, (c >= 6 && c <= 8)};
            got = dut_out();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL illegal cyc=%0d got=%b exp=%b", c, got, exp);
            end
            tick((c >= 5 && c <= 7) ? 2'b11 : 2'b00);
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] got, exp;
        release_rst();
        for (int c = 1; c <= 5; c++) tick((c == 5) ? 2'b10 : 2'b00);
        total++;
        if (bus.switching !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_pending got=%b exp=1", bus.switching);
        end
        bus.dfs_sel = 2'b00;
        rst = 1'b1;
        #1;
        got = dut_out();
        total++;
        if (got !== 6'b0) begin
            bad++;
            $display("FAIL reset_mid_immediate got=%b exp=%b", got, 6'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int c = 1; c <= 12; c++) begin
            exp = {(c % 4 == 0), 2'b00, 1'b0, 1'b0, 1'b0};
            got = dut_out();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL reset_mid_resume cyc=%0d got=%b exp=%b", c, got, exp);
            end
            tick(2'b00);
        end
`ifdef DFS_STATS_EN
        total++;
        if (bus.switch_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_mid_count got=%0d exp=0", bus.switch_count);
        end
`endif
    endtask

    task automatic test_random();
        logic [5:0] got, exp;
        logic [1:0] sel;
        release_rst();
        sel = 2'b00;
        for (int c = 1; c <= 3000; c++) begin
            got = dut_out();
            exp = model_out();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL random cyc=%0d got=%b exp=%b", c, got, exp);
            end
`ifdef DFS_STATS_EN
            total++;
            if (bus.switch_count !== 16'(m_cnt)) begin
                bad++;
                $display("FAIL random_count cyc=%0d got=%0d exp=%0d", c, bus.switch_count, m_cnt);
            end
`endif
            if ($urandom_range(7) == 0) sel = 2'($urandom_range(3));
            tick(sel);
        end
    endtask

    initial begin
        bus.dfs_sel = 2'b00;
        test_reset();
        test_low_cadence();
        test_switch_high_med();
        test_cancel();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
